mdu_sequencer: RTL

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_pkg.sv | 50 +++++
 rtl/mdu_sequencer_if.sv | 31 +++
 rtl/mdu_iter_core.sv | 61 ++++++
 rtl/mdu_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared op-codes, FSM state type and width default for the
//            iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Any code in the 01xxx group is an M-extension op.
  function automatic logic is_mop(input logic [4:0] sel);
    return (sel & 5'b11000) == 5'b01000;
  endfunction

  // Divide-family ops (DIV/DIVU/REM/REMU) have bit 2 set inside the group.
  function automatic logic is_div_op(input logic [4:0] sel);
    return is_mop(sel) && sel[2];
  endfunction

  // rs1 is interpreted as two's complement.
  function automatic logic a_signed(input logic [4:0] sel);
    return (sel == OP_MUL) || (sel == OP_MULH) || (sel == OP_MULHSU) ||
           (sel == OP_DIV) || (sel == OP_REM);
  endfunction

  // rs2 is interpreted as two's complement.
  function automatic logic b_signed(input logic [4:0] sel);
    return (sel == OP_MUL) || (sel == OP_MULH) ||
           (sel == OP_DIV) || (sel == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer_if
// Purpose  : Request/result bundle between the pipeline and the MDU.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_sequencer_if
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            i_start;
  logic [4:0]      i_select;
  logic [XLEN-1:0] i_data1;
  logic [XLEN-1:0] i_data2;
  logic            i_flush;
  logic            o_busy;
  logic            o_result_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_select, i_data1, i_data2, i_flush,
    input  o_busy, o_result_valid, o_result
  );

  modport slave (
    input  i_start, i_select, i_data1, i_data2, i_flush,
    output o_busy, o_result_valid, o_result
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter_core
// Purpose  : One-bit-per-cycle datapath on unsigned magnitudes. A single
//            2*XLEN accumulator serves both shift-add multiply
//            ({product_hi, multiplier}) and restoring divide
//            ({partial_remainder, dividend/quotient}).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_load,
  input  wire logic              i_step,
  input  wire logic              i_is_div,
  input  wire logic [XLEN-1:0]   i_init,
  input  wire logic [XLEN-1:0]   i_opnd,
  output logic      [2*XLEN-1:0] o_acc_next
);

  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN:0]     w_sum;
  logic [XLEN+1:0]   w_diff;

  // One iteration: conditional add + right shift, or trial subtract + left shift.
  always_comb begin
    w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
    w_diff = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, i_opnd};
    w_acc_next = r_acc;
    if (i_is_div) begin
      // Top two bits are 00 when the shifted remainder covers the divisor, 11 on borrow.
      if (w_diff[XLEN+1:XLEN] == 2'b00) begin
        w_acc_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
      end
    end else if (r_acc[0]) begin
      w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    end else begin
      w_acc_next = {1'b0, r_acc[2*XLEN-1:1]};
    end
  end

  assign o_acc_next = w_acc_next;

  // Accumulator: seeded at accept, advanced once per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= {{XLEN{1'b0}}, i_init};
    end else if (i_step) begin
      r_acc <= w_acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : Iterative RV M-extension unit: IDLE/CALC/DONE control, cycle
//            counter, divide special cases and final sign correction around
//            the unsigned mdu_iter_core datapath.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input wire logic        clk,
  input wire logic        rst_n,
  mdu_sequencer_if.slave  bus
);

  localparam int              C_CW       = $clog2(XLEN);
  localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(XLEN - 1);
  localparam logic [XLEN-1:0] C_MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [C_CW-1:0]   r_cnt;
  logic [4:0]        r_sel;
  logic [XLEN-1:0]   r_d1;
  logic [XLEN-1:0]   r_d2;
  logic [XLEN-1:0]   r_result;
  logic              r_busy;
  logic              r_valid;

  logic              w_accept;
  logic              w_in_sa;
  logic              w_in_sb;
  logic [XLEN-1:0]   w_init;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_result;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_is_div;
  logic [XLEN-1:0]   w_opnd;
  logic              w_last;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_calc_result;

  // Request decode: acceptance, special-case detection and seed magnitude.
  always_comb begin
    w_accept   = (r_state == ST_IDLE) && bus.i_start && !bus.i_flush && is_mop(bus.i_select);
    w_in_sa    = a_signed(bus.i_select) & bus.i_data1[XLEN-1];
    w_in_sb    = b_signed(bus.i_select) & bus.i_data2[XLEN-1];
    // Multiply seeds the multiplier (rs2); divide seeds the dividend (rs1).
    w_init     = is_div_op(bus.i_select) ? (w_in_sa ? -bus.i_data1 : bus.i_data1)
                                         : (w_in_sb ? -bus.i_data2 : bus.i_data2);
    w_div_zero = is_div_op(bus.i_select) && (bus.i_data2 == '0);
    w_ovf      = ((bus.i_select == OP_DIV) || (bus.i_select == OP_REM)) &&
                 (bus.i_data1 == C_MIN_INT) && (bus.i_data2 == '1);
    w_special  = w_div_zero | w_ovf;
    w_spec_result = '0;
    if (w_div_zero) begin
      w_spec_result = ((bus.i_select == OP_DIV) || (bus.i_select == OP_DIVU)) ? '1 : bus.i_data1;
    end else if (bus.i_select == OP_DIV) begin
      w_spec_result = C_MIN_INT;
    end
  end

  // Held-op view: operand magnitudes feeding the core and sign correction of its output.
  always_comb begin
    w_sa       = a_signed(r_sel) & r_d1[XLEN-1];
    w_sb       = b_signed(r_sel) & r_d2[XLEN-1];
    w_mag1     = w_sa ? -r_d1 : r_d1;
    w_mag2     = w_sb ? -r_d2 : r_d2;
    w_is_div   = is_div_op(r_sel);
    w_opnd     = w_is_div ? w_mag2 : w_mag1;
    w_last     = (r_state == ST_CALC) && (r_cnt == C_CNT_LAST);
    w_prod_fix = (w_sa ^ w_sb) ? -w_acc_next : w_acc_next;
    w_quot     = (w_sa ^ w_sb) ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    w_rem      = w_sa ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
    case (r_sel)
      OP_MUL:                        w_calc_result = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_calc_result = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_calc_result = w_quot;
      OP_REM, OP_REMU:               w_calc_result = w_rem;
      default:                       w_calc_result = '0;
    endcase
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_step     (r_state == ST_CALC),
    .i_is_div   (w_is_div),
    .i_init     (w_init),
    .i_opnd     (w_opnd),
    .o_acc_next (w_acc_next)
  );

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == C_CNT_LAST) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.i_flush) w_state_nxt = ST_IDLE;
  end

  // State register with registered busy/valid derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand latches and iteration counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_sel <= bus.i_select;
      r_d1  <= bus.i_data1;
      r_d2  <= bus.i_data2;
    end else if (r_state == ST_CALC) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result register: written only on entry to DONE, so it holds between ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (w_accept && w_special) begin
      r_result <= w_spec_result;
    end else if (w_last && !bus.i_flush) begin
      r_result <= w_calc_result;
    end
  end

  assign bus.o_busy         = r_busy;
  assign bus.o_result_valid = r_valid;
  assign bus.o_result       = r_result;

endmodule
`default_nettype wire
